// File: rtl/fpu_op_scheduler.sv
// fpu_op_scheduler: round-robin front end for one shared 8-bit FPU core.
// Each accepted operation is screened by the external exception checker.
// Only clean operations are launched on the core. Every operation returns
// exactly one response carrying a status code.
module fpu_op_scheduler #(
  parameter int          TIMEOUT  = 16,
  parameter logic [7:0]  NAN_CODE = 8'h7C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [1:0] req_op0,
  input  logic [1:0] req_op1,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,
  output logic [1:0] fpu_op,
  output logic [7:0] fpu_a,
  output logic [7:0] fpu_b,
  input  logic       op_is_exception,
  output logic       fpu_start,
  input  logic       fpu_done,
  input  logic [7:0] fpu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_status
);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic [1:0] status;
  } rsp_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_INVAL = 2'b01;
  localparam logic [1:0] ST_BADOP = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b11;
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  // Both requesters packed side by side so the grant index selects directly.
  logic [1:0][1:0] op_in;
  logic [1:0][7:0] a_in, b_in;
  assign op_in = {req_op1, req_op0};
  assign a_in  = {req_a1, req_a0};
  assign b_in  = {req_b1, req_b0};

  state_t     state_q, state_d;
  logic       ptr_q;
  logic [7:0] cnt_q;
  rsp_t       rsp_q;
  logic       gnt_id;

  assign gnt_id     = req_ready[1];
  assign rsp_id     = rsp_q.id;
  assign rsp_data   = rsp_q.data;
  assign rsp_status = rsp_q.status;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs. The grant is live only in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    fpu_start = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid == 2'b11) req_ready = ptr_q ? 2'b10 : 2'b01;
        else                    req_ready = req_valid;
        if (|req_valid) state_d = CHECK;
      end
      CHECK: begin
        if (fpu_op == 2'b11 || op_is_exception) state_d = RESP;
        else                                    state_d = ISSUE;
      end
      ISSUE: begin
        fpu_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (fpu_done || cnt_q == LAST_CNT) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, wait counter, response capture and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_op <= 2'b00;
      fpu_a  <= 8'h00;
      fpu_b  <= 8'h00;
      cnt_q  <= 8'h00;
      ptr_q  <= 1'b0;
      rsp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_valid) begin
          fpu_op   <= op_in[gnt_id];
          fpu_a    <= a_in[gnt_id];
          fpu_b    <= b_in[gnt_id];
          rsp_q.id <= gnt_id;
        end
        CHECK: begin
          // A reserved opcode takes precedence over the checker flag.
          if (fpu_op == 2'b11) begin
            rsp_q.status <= ST_BADOP;
            rsp_q.data   <= 8'h00;
          end else if (op_is_exception) begin
            rsp_q.status <= ST_INVAL;
            rsp_q.data   <= NAN_CODE;
          end
        end
        ISSUE: cnt_q <= 8'h00;
        WAIT: begin
          cnt_q <= cnt_q + 8'h01;
          // A done pulse on the final wait cycle still counts as success.
          if (fpu_done) begin
            rsp_q.status <= ST_OK;
            rsp_q.data   <= fpu_result;
          end else if (cnt_q == LAST_CNT) begin
            rsp_q.status <= ST_TMO;
            rsp_q.data   <= NAN_CODE;
          end
        end
        RESP: if (rsp_ready) ptr_q <= ~rsp_q.id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Bench for fpu_op_scheduler. It contains a stub exception checker, a
// latency-programmable core model, and an accept-time reference model that
// feeds a response scoreboard.
module tb_fpu_op_scheduler;
  localparam int         T   = 4;
  localparam logic [7:0] NAN = 8'h7C;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00, req_ready;
  logic [1:0] req_op0 = 2'b00, req_op1 = 2'b00;
  logic [7:0] req_a0 = 8'h00, req_b0 = 8'h00, req_a1 = 8'h00, req_b1 = 8'h00;
  logic [1:0] fpu_op;
  logic [7:0] fpu_a, fpu_b;
  logic       op_is_exception;
  logic       fpu_start;
  logic       fpu_done = 1'b0;
  logic [7:0] fpu_result = 8'h00;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;

  fpu_op_scheduler #(.TIMEOUT(T), .NAN_CODE(NAN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .op_is_exception(op_is_exception),
    .fpu_start(fpu_start), .fpu_done(fpu_done), .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_status(rsp_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Checker stub: an all-ones exponent on either operand is exceptional.
  function automatic bit is_exc(logic [7:0] a, logic [7:0] b);
    return (a[6:3] == 4'hF) || (b[6:3] == 4'hF);
  endfunction
  assign op_is_exception = is_exc(fpu_a, fpu_b);

  typedef struct {
    int id;
    int data;
    int status;
    int cyc;
    int starts;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Values shared between stimulus, model and core.
  logic [1:0] acc_flag = 2'b00;
  bit         use_dir = 1'b1;
  int         dir_lat = 1;
  int         dir_res = 0;
  int         pending_lat = 0;
  int         pending_res = 0;
  int         grants[$];

  // Core model: done arrives pending_lat cycles after the start cycle (0 = never).
  int cd = 0;
  bit st_seen = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      st_seen = fpu_start;
      @(posedge clk);
      #1;
      fpu_done   = 1'b0;
      fpu_result = 8'($urandom);
      if (st_seen) cd = pending_lat;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          fpu_done   = 1'b1;
          fpu_result = 8'(pending_res);
        end
      end
    end
  end

  // Monitor: predict at accept, pop and compare at every response transfer.
  bit         mptr = 1'b0, in_rsp = 1'b0, held = 1'b0;
  int         first_cyc = 0, starts = 0;
  int         m_id, m_lat, m_res;
  logic [1:0] m_op;
  logic [7:0] m_a, m_b;
  int         p_id, p_data, p_st;
  exp_t       e, ex;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_flag = 2'b00; held = 1'b0; in_rsp = 1'b0; starts = 0; mptr = 1'b0;
      end else begin
        acc_flag = req_valid & req_ready;
        chk("ready_two_hot", int'(req_ready == 2'b11), 0);
        chk("ready_without_valid", int'(|(req_ready & ~req_valid)), 0);
        if (|acc_flag) begin
          m_id = int'(acc_flag[1]);
          if (req_valid == 2'b11) chk("rr_winner", m_id, int'(mptr));
          grants.push_back(m_id);
          m_op  = m_id ? req_op1 : req_op0;
          m_a   = m_id ? req_a1 : req_a0;
          m_b   = m_id ? req_b1 : req_b0;
          m_lat = use_dir ? dir_lat : $urandom_range(0, 6);
          m_res = use_dir ? dir_res : $urandom_range(0, 255);
          ex.id = m_id;
          if (m_op == 2'b11) begin
            ex.data = 0;    ex.status = 2; ex.cyc = cyc + 2;         ex.starts = 0;
          end else if (is_exc(m_a, m_b)) begin
            ex.data = NAN;  ex.status = 1; ex.cyc = cyc + 2;         ex.starts = 0;
          end else if (m_lat >= 1 && m_lat <= T) begin
            ex.data = m_res; ex.status = 0; ex.cyc = cyc + 3 + m_lat; ex.starts = 1;
          end else begin
            ex.data = NAN;  ex.status = 3; ex.cyc = cyc + 3 + T;     ex.starts = 1;
          end
          pending_lat = m_lat;
          pending_res = m_res;
          q.push_back(ex);
        end
        if (fpu_start) starts++;
        if (rsp_valid) begin
          if (!in_rsp) begin in_rsp = 1'b1; first_cyc = cyc; end
          chk("ready_during_resp", int'(req_ready), 0);
          if (held) begin
            chk("hold_id", int'(rsp_id), p_id);
            chk("hold_data", int'(rsp_data), p_data);
            chk("hold_status", int'(rsp_status), p_st);
          end
          if (rsp_ready) begin
            if (q.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
              e = q.pop_front();
              chk("rsp_id", int'(rsp_id), e.id);
              chk("rsp_data", int'(rsp_data), e.data);
              chk("rsp_status", int'(rsp_status), e.status);
              chk("rsp_first_cycle", first_cyc, e.cyc);
              chk("start_pulses", starts, e.starts);
              mptr = ~e.id[0];
            end
            in_rsp = 1'b0;
            starts = 0;
          end
        end else if (held) chk("rsp_dropped", 0, 1);
        held   = rsp_valid & ~rsp_ready;
        p_id   = int'(rsp_id);
        p_data = int'(rsp_data);
        p_st   = int'(rsp_status);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(bit id, logic [1:0] op, logic [7:0] a, logic [7:0] b);
    if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
    else    begin req_op0 = op; req_a0 = a; req_b0 = b; end
  endtask

  task automatic send(bit id, logic [1:0] op, logic [7:0] a, logic [7:0] b,
                      int lat, int res);
    bit got = 1'b0;
    dir_lat = lat;
    dir_res = res;
    set_req(id, op, a, b);
    req_valid[id] = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      if (acc_flag[id]) got = 1'b1;
    end
    req_valid[id] = 1'b0;
    chk("accept_seen", int'(got), 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (q.size() == 0 && !rsp_valid) break;
      tick();
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
    chk({tag, "_fpu_start"}, int'(fpu_start), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, int'(rsp_id), 0);
    chk({tag, "_rsp_status"}, int'(rsp_status), 0);
    chk({tag, "_rsp_data"}, int'(rsp_data), 0);
    chk({tag, "_fpu_op"}, int'(fpu_op), 0);
    chk({tag, "_fpu_a"}, int'(fpu_a), 0);
    chk({tag, "_fpu_b"}, int'(fpu_b), 0);
  endtask

  task automatic rand_operand(output logic [7:0] v);
    logic [3:0] ex4;
    ex4 = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    v = {1'($urandom), ex4, 3'($urandom)};
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1);
  end

  initial begin
    bit         got;
    int         g[$];
    int         base;
    logic [7:0] ra, rb;
    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    rsp_ready = 1'b1;

    // Directed test-plan cases.
    send(1'b0, 2'b00, 8'h38, 8'h38, 3, 8'h40); drain();   // single add
    send(1'b0, 2'b00, 8'h78, 8'hF8, 3, 8'h11); drain();   // exception screen
    send(1'b1, 2'b11, 8'h12, 8'h34, 3, 8'h22); drain();   // bad opcode
    send(1'b1, 2'b11, 8'h78, 8'h10, 3, 8'h23); drain();   // bad opcode beats exception
    send(1'b0, 2'b01, 8'h11, 8'h22, 0, 8'h33); drain();   // timeout, no done
    send(1'b1, 2'b10, 8'h21, 8'h19, 5, 8'h44); drain();   // done one cycle too late
    send(1'b0, 2'b00, 8'h08, 8'h10, 4, 8'h55); drain();   // done on last wait cycle

    // Backpressure: response held while another request waits.
    rsp_ready = 1'b0;
    send(1'b1, 2'b00, 8'h10, 8'h20, 2, 8'h5A);
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      if (rsp_valid) got = 1'b1;
      else tick();
    end
    chk("bp_rsp_seen", int'(got), 1);
    set_req(1'b0, 2'b00, 8'h18, 8'h18);
    req_valid[0] = 1'b1;
    dir_lat = 1;
    dir_res = 8'h66;
    repeat (5) begin
      tick();
      chk("bp_req_ready", int'(req_ready), 0);
      chk("bp_rsp_valid", int'(rsp_valid), 1);
    end
    rsp_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      if (acc_flag[0]) got = 1'b1;
    end
    req_valid[0] = 1'b0;
    chk("bp_second_accept", int'(got), 1);
    drain();

    // Reset in WAIT; the core's pending done lands after the abort.
    send(1'b1, 2'b00, 8'h28, 8'h30, 4, 8'h77);
    tick(); tick(); tick();
    chk("pre_abort_a", int'(fpu_a), 8'h28);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    q.delete();
    tick(); tick();
    rst_n = 1'b1;

    // Round robin with both requesters held valid.
    dir_lat = 1;
    dir_res = 8'h12;
    set_req(1'b0, 2'b00, 8'h38, 8'h30);
    set_req(1'b1, 2'b01, 8'h38, 8'h30);
    req_valid = 2'b11;
    for (int k = 0; k < 300 && g.size() < 4; k++) begin
      tick();
      if (acc_flag[0]) g.push_back(0);
      if (acc_flag[1]) g.push_back(1);
    end
    req_valid = 2'b00;
    chk("rr_count", g.size(), 4);
    for (int i = 0; i < 4 && i < g.size(); i++) chk("rr_order", g[i], i % 2);
    drain();

    // Randomized traffic with random backpressure and core latency.
    use_dir = 1'b0;
    base = grants.size();
    for (int k = 0; k < 20000; k++) begin
      tick();
      if (grants.size() >= base + 150) break;
      for (int i = 0; i < 2; i++) begin
        if (acc_flag[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            rand_operand(ra);
            rand_operand(rb);
            set_req(i[0], 2'($urandom_range(0, 3)), ra, rb);
            req_valid[i] = 1'b1;
          end else req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 2'b00;
    chk("rand_ops", int'(grants.size() >= base + 150), 1);
    rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
